// File: rtl/mapas.sv
// Occupancy-grid mapper. A rising edge on novoDado marks the robot cell, then traces
// the front, right and left rays into a grid of 2-bit cells, writing one cell per clock.
module mapasCelula (
    input  logic       clock,
    input  logic       reset,
    input  logic       escrever,
    input  logic [1:0] valor,
    output logic [1:0] celula
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            celula <= 2'd0;
        end else if (escrever) begin
            // A robot mark always wins. An obstacle yields only to a robot mark.
            // A free mark fills only unknown cells.
            case (valor)
                2'd3:    celula <= 2'd3;
                2'd2:    if (celula != 2'd3) celula <= 2'd2;
                2'd1:    if (celula == 2'd0) celula <= 2'd1;
                default: ;
            endcase
        end
    end
endmodule

module mapas #(
    parameter int TamanhoMalha     = 8,
    parameter int tamanhoDistancia = 4
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [tamanhoDistancia-1:0]                   posicaoAtualnoEixoX,
    input  logic [tamanhoDistancia-1:0]                   posicaoAtualnoEixoY,
    input  logic                                          direcaoAtual,
    input  logic [tamanhoDistancia-1:0]                   distanciaFrente,
    input  logic [tamanhoDistancia-1:0]                   distanciaDireita,
    input  logic [tamanhoDistancia-1:0]                   distanciaEsquerda,
    input  logic                                          novoDado,
    output logic [TamanhoMalha-1:0][TamanhoMalha-1:0][1:0] malha,
    output logic                                          operacaoFinalizada
);
    localparam int W = tamanhoDistancia;

    typedef enum logic [2:0] {IDLE, ROBO, FRENTE, DIREITA, ESQUERDA, DONE} estado_t;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         dir;
        logic [W-1:0] dF;
        logic [W-1:0] dD;
        logic [W-1:0] dE;
    } amostra_t;

    estado_t         estado, proxEstado;
    amostra_t        amostra;
    logic            novoDadoAnt;
    logic [W-1:0]    passo;
    logic [W-1:0]    distAtual;
    logic            inicio, raioFim;
    logic signed [W:0] baseX, baseY, k, alvoX, alvoY;
    logic            escrever, dentro;
    logic [1:0]      valor;

    assign inicio  = (estado == IDLE) && novoDado && !novoDadoAnt;
    assign raioFim = (distAtual == '0) || (passo == distAtual);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= IDLE;
        else        estado <= proxEstado;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            novoDadoAnt <= 1'b0;
            amostra     <= '0;
            passo       <= W'(1);
        end else begin
            novoDadoAnt <= novoDado;
            if (inicio)
                amostra <= {posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcaoAtual,
                            distanciaFrente, distanciaDireita, distanciaEsquerda};
            // Outside the ray states distAtual is 0, so passo is already 1 on entry to the next ray.
            passo <= raioFim ? W'(1) : passo + W'(1);
        end
    end

    always_comb begin
        distAtual = '0;
        case (estado)
            FRENTE:   distAtual = amostra.dF;
            DIREITA:  distAtual = amostra.dD;
            ESQUERDA: distAtual = amostra.dE;
            default:  ;
        endcase
    end

    always_comb begin
        proxEstado = estado;
        case (estado)
            IDLE:     if (inicio)  proxEstado = ROBO;
            ROBO:                  proxEstado = FRENTE;
            FRENTE:   if (raioFim) proxEstado = DIREITA;
            DIREITA:  if (raioFim) proxEstado = ESQUERDA;
            ESQUERDA: if (raioFim) proxEstado = DONE;
            DONE:                  proxEstado = IDLE;
            default:               proxEstado = IDLE;
        endcase
    end

    // Targets are signed and one bit wider than the inputs, so a ray that runs past either edge goes out of bounds and is never written.
    always_comb begin
        baseX              = $signed({1'b0, amostra.x});
        baseY              = $signed({1'b0, amostra.y});
        k                  = $signed({1'b0, passo});
        alvoX              = baseX;
        alvoY              = baseY;
        escrever           = 1'b0;
        valor              = 2'd0;
        operacaoFinalizada = 1'b1;
        case (estado)
            ROBO: begin
                escrever           = 1'b1;
                valor              = 2'd3;
                operacaoFinalizada = 1'b0;
            end
            FRENTE, DIREITA, ESQUERDA: begin
                escrever           = (distAtual != '0);
                valor              = (passo == distAtual) ? 2'd2 : 2'd1;
                operacaoFinalizada = 1'b0;
                if (estado == FRENTE)
                    alvoY = amostra.dir ? baseY + k : baseY - k;
                else if (estado == DIREITA)
                    alvoX = amostra.dir ? baseX + k : baseX - k;
                else
                    alvoX = amostra.dir ? baseX - k : baseX + k;
            end
            default: ;
        endcase
    end

    assign dentro = (int'(alvoX) >= 0) && (int'(alvoX) < TamanhoMalha) &&
                    (int'(alvoY) >= 0) && (int'(alvoY) < TamanhoMalha);

    for (genvar gx = 0; gx < TamanhoMalha; gx++) begin : genX
        for (genvar gy = 0; gy < TamanhoMalha; gy++) begin : genY
            logic escreveCel;
            assign escreveCel = escrever && dentro && (int'(alvoX) == gx) && (int'(alvoY) == gy);
            mapasCelula uCel (
                .clock    (clock),
                .reset    (reset),
                .escrever (escreveCel),
                .valor    (valor),
                .celula   (malha[gx][gy])
            );
        end
    end
endmodule

// File: tb/tb_mapas.sv
// Directed bench for mapas. It runs the hand-worked scenarios and compares the grid and
// busy-cycle counts against expected values written out by hand.
module tb_mapas;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] posX, posY, dF, dD, dE;
    logic       dir, novoDado;
    logic [7:0][7:0][1:0] malha;
    logic [7:0][7:0][1:0] esp;
    logic       operacaoFinalizada;
    int         nChecks = 0;
    int         nPass   = 0;

    mapas #(.TamanhoMalha(8), .tamanhoDistancia(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .posicaoAtualnoEixoX (posX),
        .posicaoAtualnoEixoY (posY),
        .direcaoAtual        (dir),
        .distanciaFrente     (dF),
        .distanciaDireita    (dD),
        .distanciaEsquerda   (dE),
        .novoDado            (novoDado),
        .malha               (malha),
        .operacaoFinalizada  (operacaoFinalizada)
    );

    always #5 clock = ~clock;

    task automatic confere(input string tag, input logic [127:0] obs, input logic [127:0] esperado);
        nChecks++;
        if (obs === esperado) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, esperado);
    endtask

    task automatic ajusta(input int x, input int y, input int d, input int f, input int r, input int l);
        posX = 4'(x); posY = 4'(y); dir = 1'(d);
        dF = 4'(f); dD = 4'(r); dE = 4'(l);
    endtask

    // Counts the busy cycles that follow the start edge. With perturbar set, it also
    // toggles novoDado and changes the inputs while the update is running.
    task automatic medir(input string tag, input int esperado, input bit perturbar);
        int ciclos = 0;
        @(posedge clock); #1;
        while (!operacaoFinalizada && ciclos < 100) begin
            ciclos++;
            if (perturbar && ciclos == 2) novoDado = 1'b0;
            if (perturbar && ciclos == 3) begin
                ajusta(6, 6, 1, 2, 2, 2);
                novoDado = 1'b1;
            end
            @(posedge clock); #1;
        end
        confere(tag, 128'(ciclos), 128'(esperado));
    endtask

    task automatic rodada(input int x, input int y, input int d, input int f, input int r,
                          input int l, input string tag, input int busy, input bit perturbar);
        @(negedge clock); novoDado = 1'b0;
        @(negedge clock); ajusta(x, y, d, f, r, l); novoDado = 1'b1;
        medir(tag, busy, perturbar);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; novoDado = 1'b0; ajusta(0, 0, 0, 0, 0, 0); esp = '0;
        repeat (2) @(negedge clock);
        confere("reset_fin", 128'(operacaoFinalizada), 128'(1'b1));
        confere("reset_grid", malha, esp);

        // Scenario 1: novoDado is held high through reset release.
        ajusta(3, 0, 1, 1, 2, 1); novoDado = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        medir("s1_busy", 5, 1'b0);
        esp[3][0] = 2'd3; esp[3][1] = 2'd2; esp[4][0] = 2'd1; esp[5][0] = 2'd2; esp[2][0] = 2'd2;
        confere("s1_grid", malha, esp);
        repeat (4) @(posedge clock); #1;
        confere("s1_noRestart", 128'(operacaoFinalizada), 128'(1'b1));
        confere("s1_gridHeld", malha, esp);

        // Scenario 2: the front and left rays leave the grid.
        rodada(0, 7, 1, 3, 1, 2, "s2_busy", 7, 1'b0);
        esp[0][7] = 2'd3; esp[1][7] = 2'd2;
        confere("s2_grid", malha, esp);

        // Scenario 3: heading -Y, with only the left ray (+X) active.
        rodada(4, 4, 0, 0, 0, 3, "s3_busy", 6, 1'b0);
        esp[4][4] = 2'd3; esp[5][4] = 2'd1; esp[6][4] = 2'd1; esp[7][4] = 2'd2;
        confere("s3_grid", malha, esp);

        // Scenario 4: free must not overwrite an obstacle or a visited cell.
        rodada(5, 3, 0, 4, 0, 0, "s4a_busy", 7, 1'b0);
        esp[5][3] = 2'd3; esp[5][2] = 2'd1; esp[5][1] = 2'd1;
        confere("s4a_grid", malha, esp);
        rodada(1, 0, 1, 0, 3, 0, "s4b_busy", 6, 1'b0);
        esp[1][0] = 2'd3; esp[4][0] = 2'd2;
        confere("s4b_grid", malha, esp);
        confere("s4b_visitedKept", 128'(malha[3][0]), 128'(2'd3));

        // Scenario 5: reset is asserted asynchronously during the right ray.
        @(negedge clock); novoDado = 1'b0;
        @(negedge clock); ajusta(3, 0, 1, 1, 2, 1); novoDado = 1'b1;
        @(posedge clock); #1;
        confere("s5_busyBefore", 128'(operacaoFinalizada), 128'(1'b0));
        @(posedge clock); @(posedge clock); #2;
        reset = 1'b0; #1;
        esp = '0;
        confere("s5_asyncFin", 128'(operacaoFinalizada), 128'(1'b1));
        confere("s5_asyncGrid", malha, esp);
        novoDado = 1'b0;
        @(negedge clock); reset = 1'b1;
        repeat (5) @(posedge clock); #1;
        confere("s5_idleFin", 128'(operacaoFinalizada), 128'(1'b1));
        confere("s5_idleGrid", malha, esp);
        rodada(3, 0, 1, 1, 2, 1, "s5_restart", 5, 1'b0);
        esp[3][0] = 2'd3; esp[3][1] = 2'd2; esp[4][0] = 2'd1; esp[5][0] = 2'd2; esp[2][0] = 2'd2;
        confere("s5_grid", malha, esp);

        // Scenario 6: a new edge while busy is ignored; a fresh edge after DONE starts a new update.
        rodada(2, 6, 0, 2, 1, 0, "s6_busy", 5, 1'b1);
        esp[2][6] = 2'd3; esp[2][5] = 2'd1; esp[2][4] = 2'd2; esp[1][6] = 2'd2;
        confere("s6_grid", malha, esp);
        repeat (3) @(posedge clock); #1;
        confere("s6_ignoredFin", 128'(operacaoFinalizada), 128'(1'b1));
        confere("s6_ignoredGrid", malha, esp);
        rodada(7, 2, 1, 1, 0, 0, "s6_fresh", 4, 1'b0);
        esp[7][2] = 2'd3; esp[7][3] = 2'd2;
        confere("s6_freshGrid", malha, esp);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
